// File: rtl/rds_bitstream_gen.sv
// RDS baseband encoder: checkworded 104-bit groups, differential coding and biphase level, paced by a
// fractional half-bit NCO. Optional RDS_CPRIME_EN adds the grp_cprime input selecting offset C' for block 3.
module rds_bitstream_gen #(
  parameter int HB_NUM = 4750,
  parameter int HB_DEN = 50000000,
  parameter int ACC_W  = 26
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic [15:0] grp_a,
  input  logic [15:0] grp_b,
  input  logic [15:0] grp_c,
  input  logic [15:0] grp_d,
  input  logic        grp_valid,
  output logic        grp_ready,
`ifdef RDS_CPRIME_EN
  input  logic        grp_cprime,
`endif
  output logic        rds_bit,
  output logic        rds_bpsk,
  output logic        bit_stb,
  output logic        grp_stb
);

  localparam logic [ACC_W:0] NUM_X     = (ACC_W+1)'(HB_NUM);
  localparam logic [ACC_W:0] DEN_X     = (ACC_W+1)'(HB_DEN);
  localparam logic [4:0]     INFO_BITS = 5'd16;
  localparam logic [4:0]     LAST_BIT  = 5'd25;

  function automatic logic [9:0] crc_step(input logic [9:0] crc_i, input logic d);
    logic fb;
    fb = d ^ crc_i[9];
    return {crc_i[8:0], 1'b0} ^ (fb ? 10'h1B9 : 10'h000);
  endfunction

  function automatic logic [9:0] offset_word(input logic [1:0] blk_i, input logic cprime);
    logic [9:0] off;
    case (blk_i)
      2'd0:    off = 10'h0FC;
      2'd1:    off = 10'h198;
      2'd2:    off = cprime ? 10'h350 : 10'h168;
      default: off = 10'h1B4;
    endcase
    return off;
  endfunction

  logic [ACC_W-1:0] acc;
  logic             half;
  logic             started;
  logic [4:0]       bit_idx;
  logic [1:0]       blk;
  logic [9:0]       crc;
  logic             buf_full;
  logic [15:0]      buf_a, buf_b, buf_c, buf_d;
  logic [15:0]      cur_a, cur_b, cur_c, cur_d;
  logic             cur_cp;

  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             hb_tick;
  logic             bit_start;
  logic             mid_tick;
  logic             grp_bound;
  logic             load;
  logic [15:0]      word;
  logic [9:0]       crc_base;
  logic [9:0]       chk;
  logic [3:0]       info_pos;
  logic [3:0]       chk_pos;
  logic             d_bit;
  logic             e_bit;

  always_comb begin
    acc_sum = {1'b0, acc} + NUM_X;
    hb_tick = (acc_sum >= DEN_X);
    acc_nxt = ACC_W'(hb_tick ? acc_sum - DEN_X : acc_sum);
  end

  // Before the first tick there is no bit in flight, so that tick opens bit 0 instead of a second half.
  assign bit_start = hb_tick & (half | ~started);
  assign mid_tick  = hb_tick & started & ~half;
  assign grp_bound = (blk == 2'd0) && (bit_idx == 5'd0);
  assign load      = bit_start & started & grp_bound & buf_full;
  assign grp_ready = ~buf_full;

  always_comb begin
    case (blk)
      2'd0:    word = load ? buf_a : cur_a;
      2'd1:    word = cur_b;
      2'd2:    word = cur_c;
      default: word = cur_d;
    endcase
    info_pos = 4'd15 - bit_idx[3:0];
    chk_pos  = 4'(LAST_BIT - bit_idx);
    crc_base = (bit_idx == 5'd0) ? 10'h000 : crc;
    chk      = crc ^ offset_word(blk, cur_cp);
    d_bit    = (bit_idx < INFO_BITS) ? word[info_pos] : chk[chk_pos];
    e_bit    = d_bit ^ rds_bit;
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      half     <= 1'b0;
      started  <= 1'b0;
      bit_idx  <= 5'd0;
      blk      <= 2'd0;
      crc      <= 10'h000;
      rds_bit  <= 1'b0;
      rds_bpsk <= 1'b0;
      bit_stb  <= 1'b0;
      grp_stb  <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      bit_stb <= bit_start;
      grp_stb <= bit_start & grp_bound;
      if (bit_start) begin
        started  <= 1'b1;
        half     <= 1'b0;
        rds_bit  <= e_bit;
        rds_bpsk <= e_bit;
        if (bit_idx < INFO_BITS) begin
          crc <= crc_step(crc_base, d_bit);
        end
        if (bit_idx == LAST_BIT) begin
          bit_idx <= 5'd0;
          blk     <= blk + 2'd1;
        end else begin
          bit_idx <= bit_idx + 5'd1;
        end
      end else if (mid_tick) begin
        half     <= 1'b1;
        rds_bpsk <= ~rds_bit;
      end
    end
  end

  // A load and an accept never coincide: the buffer is full for one and empty for the other.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_a    <= 16'h0000;
      buf_b    <= 16'h0000;
      buf_c    <= 16'h0000;
      buf_d    <= 16'h0000;
      cur_a    <= 16'h0000;
      cur_b    <= 16'h0000;
      cur_c    <= 16'h0000;
      cur_d    <= 16'h0000;
    end else if (load) begin
      buf_full <= 1'b0;
      cur_a    <= buf_a;
      cur_b    <= buf_b;
      cur_c    <= buf_c;
      cur_d    <= buf_d;
    end else if (grp_valid && !buf_full) begin
      buf_full <= 1'b1;
      buf_a    <= grp_a;
      buf_b    <= grp_b;
      buf_c    <= grp_c;
      buf_d    <= grp_d;
    end
  end

`ifdef RDS_CPRIME_EN
  logic buf_cp;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      buf_cp <= 1'b0;
      cur_cp <= 1'b0;
    end else if (load) begin
      cur_cp <= buf_cp;
    end else if (grp_valid && !buf_full) begin
      buf_cp <= grp_cprime;
    end
  end
`else
  assign cur_cp = 1'b0;
`endif

endmodule

// File: tb/tb_rds_bitstream_gen.sv
// Bench for rds_bitstream_gen: random groups decoded from rds_bit and compared with a polynomial-division
// reference model; NCO timing checked against the ideal tick schedule floor(n*HB_NUM/HB_DEN).
module tb_rds_bitstream_gen;

  localparam int HB_NUM    = 3;
  localparam int HB_DEN    = 7;
  localparam int ACC_W     = 3;
  localparam int RATE_BITS = 100;
  localparam int TMO       = 4000;
`ifdef RDS_CPRIME_EN
  localparam bit CP_EN = 1'b1;
`else
  localparam bit CP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] grp_a = '0, grp_b = '0, grp_c = '0, grp_d = '0;
  logic        grp_valid = 1'b0;
  logic        grp_ready;
  logic        rds_bit, rds_bpsk, bit_stb, grp_stb;
`ifdef RDS_CPRIME_EN
  logic        grp_cprime = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  rds_bitstream_gen #(.HB_NUM(HB_NUM), .HB_DEN(HB_DEN), .ACC_W(ACC_W)) dut (
    .clk_25m   (clk),
    .rst_n     (rst_n),
    .grp_a     (grp_a),
    .grp_b     (grp_b),
    .grp_c     (grp_c),
    .grp_d     (grp_d),
    .grp_valid (grp_valid),
    .grp_ready (grp_ready),
`ifdef RDS_CPRIME_EN
    .grp_cprime(grp_cprime),
`endif
    .rds_bit   (rds_bit),
    .rds_bpsk  (rds_bpsk),
    .bit_stb   (bit_stb),
    .grp_stb   (grp_stb)
  );

  always #5 clk = ~clk;

  // Reference model: checkword = (word * x^10 mod g(x)) xor offset, blocks sent MSB first.
  function automatic logic [9:0] poly_rem(input logic [15:0] w);
    logic [25:0] v;
    v = {w, 10'b0};
    for (int i = 25; i >= 10; i--)
      if (v[i]) v = v ^ (26'h5B9 << (i - 10));
    return v[9:0];
  endfunction

  function automatic logic [103:0] exp_group(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] d, input bit cp);
    logic [15:0]  w [4];
    logic [9:0]   off [4];
    logic [103:0] g;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    off[0] = 10'h0FC; off[1] = 10'h198; off[2] = cp ? 10'h350 : 10'h168; off[3] = 10'h1B4;
    g = '0;
    for (int j = 0; j < 4; j++) g[103 - 26*j -: 26] = {w[j], poly_rem(w[j]) ^ off[j]};
    return g;
  endfunction

  // Differential decoder and group collector.
  logic         rds_q1 = 1'b0;
  longint       ncyc = 0;
  int           grp_starts = 0;
  int           cur_g = -1;
  int           pos = 0;
  logic [103:0] grp_bits [0:63];
  bit           grp_cmp [0:63];

  always @(posedge clk) rds_q1 <= rds_bit;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        cur_g = -1;
      end else if (bit_stb) begin
        if (grp_stb) begin
          cur_g = grp_starts;
          grp_starts++;
          pos = 0;
        end
        if (cur_g >= 0 && cur_g < 64) begin
          grp_bits[cur_g][103 - pos] = rds_bit ^ rds_q1;
          pos++;
          if (pos == 104) begin
            grp_cmp[cur_g] = 1'b1;
            cur_g = -1;
          end
        end
      end
    end
  end

  task automatic wait_group(input int idx, output bit ok);
    int t = 0;
    while (!(idx >= 0 && idx < 64 && grp_cmp[idx]) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    ok = (idx >= 0 && idx < 64 && grp_cmp[idx]);
  endtask

  // Returns the index of the first group that starts after the accept.
  task automatic send_group(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                            input logic [15:0] d, input bit cp, output int s, output bit ok);
    int t = 0;
    @(negedge clk);
    grp_a = a; grp_b = b; grp_c = c; grp_d = d;
`ifdef RDS_CPRIME_EN
    grp_cprime = cp;
`else
    if (cp) t = 0;
`endif
    grp_valid = 1'b1;
    while (!grp_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    ok = grp_ready;
    @(posedge clk);
    #1 grp_valid = 1'b0;
    @(posedge clk);
    #1 s = grp_starts;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (rds_bit !== 1'b0) begin n_fail++; $display("FAIL reset_rds_bit: got %b want 0", rds_bit); end
    n_chk++; if (rds_bpsk !== 1'b0) begin n_fail++; $display("FAIL reset_rds_bpsk: got %b want 0", rds_bpsk); end
    n_chk++; if (bit_stb !== 1'b0) begin n_fail++; $display("FAIL reset_bit_stb: got %b want 0", bit_stb); end
    n_chk++; if (grp_stb !== 1'b0) begin n_fail++; $display("FAIL reset_grp_stb: got %b want 0", grp_stb); end
    n_chk++; if (grp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_grp_ready: got %b want 1", grp_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_group();
    bit ok;
    logic [103:0] g, e;
    wait_group(0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL zero_grp_timeout: got none want group 0"); end
    g = grp_bits[0];
    e = exp_group(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    n_chk++; if (g[103:78] !== {16'h0000, 10'h0FC}) begin
      n_fail++; $display("FAIL zero_blk1: got %h want %h", g[103:78], {16'h0000, 10'h0FC}); end
    for (int j = 1; j < 4; j++) begin
      n_chk++;
      if (g[103 - 26*j -: 26] !== e[103 - 26*j -: 26]) begin
        n_fail++; $display("FAIL zero_blk%0d: got %h want %h", j + 1, g[103 - 26*j -: 26], e[103 - 26*j -: 26]);
      end
    end
  endtask

  task automatic test_rate();
    int t = 0, cnt = 0, nb = 0, per = 0, pmin = 1 << 30, pmax = 0;
    longint lo, hi, plo, phi;
    lo  = (longint'(RATE_BITS) * 2 * HB_DEN) / HB_NUM;
    hi  = (longint'(RATE_BITS) * 2 * HB_DEN + HB_NUM - 1) / HB_NUM;
    plo = (2 * HB_DEN) / HB_NUM;
    phi = (2 * HB_DEN + HB_NUM - 1) / HB_NUM;
    @(negedge clk);
    while (!bit_stb && t < TMO) begin @(negedge clk); t++; end
    while (nb < RATE_BITS && cnt < TMO) begin
      @(negedge clk);
      cnt++; per++;
      if (bit_stb) begin
        nb++;
        if (per < pmin) pmin = per;
        if (per > pmax) pmax = per;
        per = 0;
      end
    end
    n_chk++; if (cnt < lo || cnt > hi) begin
      n_fail++; $display("FAIL rate_total: got %0d clocks want %0d..%0d", cnt, lo, hi); end
    n_chk++; if (pmin < plo || pmax > phi) begin
      n_fail++; $display("FAIL rate_period: got %0d..%0d want %0d..%0d", pmin, pmax, plo, phi); end
  endtask

  // Tick T (1-based) = floor(n*NUM/DEN); odd ticks open bits, even ticks are mid-bit.
  task automatic test_bpsk();
    longint n, tc, tp;
    logic exp_stb, exp_gstb, exp_bpsk;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n  = ncyc;
      tc = (n * HB_NUM) / HB_DEN;
      tp = ((n - 1) * HB_NUM) / HB_DEN;
      exp_stb  = (tc != tp) && (tc % 2 == 1);
      exp_gstb = exp_stb && (((tc - 1) / 2) % 104 == 0);
      exp_bpsk = (tc == 0) ? 1'b0 : ((tc % 2 == 1) ? rds_bit : ~rds_bit);
      n_chk++; if (bit_stb !== exp_stb) begin
        n_fail++; $display("FAIL bpsk_bit_stb at cycle %0d: got %b want %b", n, bit_stb, exp_stb); break; end
      n_chk++; if (grp_stb !== exp_gstb) begin
        n_fail++; $display("FAIL bpsk_grp_stb at cycle %0d: got %b want %b", n, grp_stb, exp_gstb); break; end
      n_chk++; if (rds_bpsk !== exp_bpsk) begin
        n_fail++; $display("FAIL bpsk_level at cycle %0d: got %b want %b", n, rds_bpsk, exp_bpsk); break; end
    end
  endtask

  task automatic test_checkwords();
    int s;
    bit ok, okw;
    logic [103:0] g;
    send_group(16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0, s, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL chk_accept: got ready=0 want accept"); end
    wait_group(s, okw);
    n_chk++; if (!okw) begin n_fail++; $display("FAIL chk_timeout: got none want group %0d", s); end
    g = grp_bits[s];
    n_chk++; if (g[87:78] !== 10'h145) begin n_fail++; $display("FAIL chk_blk1: got %h want 145", g[87:78]); end
    n_chk++; if (g[61:52] !== 10'h021) begin n_fail++; $display("FAIL chk_blk2: got %h want 021", g[61:52]); end
    n_chk++; if (g !== exp_group(16'h0001, 16'h0001, 16'h0, 16'h0, 1'b0)) begin
      n_fail++; $display("FAIL chk_group: got %h want %h", g, exp_group(16'h0001, 16'h0001, 16'h0, 16'h0, 1'b0)); end
  endtask

  task automatic test_random();
    logic [15:0] w [3][4];
    bit cp [3];
    int s [3];
    bit ok;
    logic [103:0] e;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) w[i][j] = 16'($urandom);
      cp[i] = 1'($urandom);
      send_group(w[i][0], w[i][1], w[i][2], w[i][3], cp[i], s[i], ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rand_accept%0d: got ready=0 want accept", i); end
    end
    for (int i = 0; i < 3; i++) begin
      wait_group(s[i], ok);
      e = exp_group(w[i][0], w[i][1], w[i][2], w[i][3], cp[i] & CP_EN);
      n_chk++; if (!ok || grp_bits[s[i]] !== e) begin
        n_fail++; $display("FAIL rand_group%0d: got %h want %h", i, grp_bits[s[i]], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] g1 [4], g2 [4];
    int s1, t = 0;
    bit ok;
    logic [103:0] e1, e2;
    for (int j = 0; j < 4; j++) begin g1[j] = 16'($urandom); g2[j] = 16'($urandom); end
    e1 = exp_group(g1[0], g1[1], g1[2], g1[3], 1'b0);
    e2 = exp_group(g2[0], g2[1], g2[2], g2[3], 1'b0);
    @(negedge clk);
    grp_a = g1[0]; grp_b = g1[1]; grp_c = g1[2]; grp_d = g1[3];
`ifdef RDS_CPRIME_EN
    grp_cprime = 1'b0;
`endif
    grp_valid = 1'b1;
    while (!grp_ready && t < TMO) begin @(negedge clk); t++; end
    @(posedge clk);
    #1;
    n_chk++; if (grp_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_fall: got %b want 0", grp_ready); end
    grp_a = g2[0]; grp_b = g2[1]; grp_c = g2[2]; grp_d = g2[3];
    @(posedge clk);
    #1 s1 = grp_starts;
    t = 0;
    while (!grp_ready && t < TMO) begin @(posedge clk); #1; t++; end
    n_chk++; if (grp_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_rise: got %b want 1", grp_ready); end
    n_chk++; if (grp_stb !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready_timing: got grp_stb=%b at ready rise want 1", grp_stb); end
    @(posedge clk);
    #1 grp_valid = 1'b0;
    n_chk++; if (grp_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_g2_accept: got ready=%b want 0", grp_ready); end
    wait_group(s1, ok);
    n_chk++; if (!ok || grp_bits[s1] !== e1) begin
      n_fail++; $display("FAIL b2b_g1: got %h want %h", grp_bits[s1], e1); end
    wait_group(s1 + 1, ok);
    n_chk++; if (!ok || grp_bits[s1 + 1] !== e2) begin
      n_fail++; $display("FAIL b2b_g2: got %h want %h", grp_bits[s1 + 1], e2); end
    wait_group(s1 + 2, ok);
    n_chk++; if (!ok || grp_bits[s1 + 2] !== e2) begin
      n_fail++; $display("FAIL b2b_repeat: got %h want %h", grp_bits[s1 + 2], e2); end
  endtask

  task automatic test_cprime();
    int s;
    bit ok;
    logic [9:0] want;
    for (int k = 0; k < 2; k++) begin
      send_group(16'h1234, 16'h5678, 16'h0000, 16'h9ABC, (k == 0), s, ok);
      wait_group(s, ok);
      want = ((k == 0) && CP_EN) ? 10'h350 : 10'h168;
      n_chk++; if (!ok || grp_bits[s][35:26] !== want) begin
        n_fail++; $display("FAIL cprime_blk3_%0d: got %h want %h", k, grp_bits[s][35:26], want); end
    end
  endtask

  task automatic test_reset_mid();
    int s, t = 0, nb = 0;
    bit ok;
    logic [103:0] z;
    z = exp_group(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    send_group(16'hBEEF, 16'h1357, 16'h2468, 16'hCAFE, 1'b0, s, ok);
    send_group(16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA, 1'b0, s, ok);
    while (nb < 40 && t < TMO) begin
      @(negedge clk);
      t++;
      if (bit_stb) nb++;
    end
    n_chk++; if (grp_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pre_ready: got %b want 0", grp_ready); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if ({rds_bit, rds_bpsk, bit_stb, grp_stb, grp_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL rmid_async: got %b want 00001", {rds_bit, rds_bpsk, bit_stb, grp_stb, grp_ready}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s = grp_starts;
    wait_group(s, ok);
    n_chk++; if (!ok || grp_bits[s] !== z) begin
      n_fail++; $display("FAIL rmid_zero: got %h want %h", grp_bits[s], z); end
    wait_group(s + 1, ok);
    n_chk++; if (!ok || grp_bits[s + 1] !== z) begin
      n_fail++; $display("FAIL rmid_buffer_cleared: got %h want %h", grp_bits[s + 1], z); end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish want finish before 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_group();
    test_rate();
    test_bpsk();
    test_checkwords();
    test_random();
    test_back_to_back();
    test_cprime();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
